// File: rtl/axi4_rd_desc_burst_gen.sv
// Splits one read descriptor into INCR AR bursts and returns the R beats as a flat stream.
// Latency: the first AR is raised 1 cycle after descriptor accept; the R path is combinational.
// Backpressure: out_ready drives rready directly; AR issue pauses when MAX_OUTSTANDING bursts await rlast.
module axi4_rd_desc_burst_gen #(
    parameter int ASIZE           = 32,
    parameter int DSIZE           = 256,
    parameter int IDSIZE          = 4,
    parameter int LSIZE           = 8,
    parameter int ADDR_STEP       = 32,
    parameter int BURST_BEATS     = 128,
    parameter int TOTAL_W         = 24,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARID            = 0
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [ASIZE-1:0]   desc_addr,
    input  logic [TOTAL_W-1:0] desc_beats,
    input  logic               desc_valid,
    output logic               desc_ready,
    output logic               busy,
    output logic               err,
    output logic [IDSIZE-1:0]  axi_arid,
    output logic [ASIZE-1:0]   axi_araddr,
    output logic [LSIZE-1:0]   axi_arlen,
    output logic [2:0]         axi_arsize,
    output logic [1:0]         axi_arburst,
    output logic               axi_arvalid,
    input  logic               axi_arready,
    input  logic [DSIZE-1:0]   axi_rdata,
    input  logic [1:0]         axi_rresp,
    input  logic               axi_rlast,
    input  logic               axi_rvalid,
    output logic               axi_rready,
    output logic [DSIZE-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SH = $clog2(ADDR_STEP);
    localparam logic [OW-1:0]      OS_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [TOTAL_W-1:0] BB     = TOTAL_W'(BURST_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ASIZE-1:0]   araddr_q, araddr_d;
    logic [LSIZE-1:0]   arlen_q, arlen_d;
    logic               arvalid_q, arvalid_d;
    logic [TOTAL_W-1:0] ar_remain_q, ar_remain_d;
    logic [TOTAL_W-1:0] rx_remain_q, rx_remain_d;
    logic [OW-1:0]      os_q, os_d;
    logic               err_q, err_d;

    logic               in_busy, accept, ar_hs, r_hs, rlast_dec, last_beat;
    logic [TOTAL_W-1:0] ar_step, ar_left;
    logic [OW-1:0]      os_nxt;

    function automatic logic [LSIZE-1:0] burst_len(input logic [TOTAL_W-1:0] remain);
        logic [TOTAL_W-1:0] n;
        n = (remain < BB) ? remain : BB;
        return LSIZE'(n - TOTAL_W'(1));
    endfunction

    assign in_busy   = (state_q != S_IDLE);
    assign accept    = desc_valid && (state_q == S_IDLE);
    assign ar_hs     = arvalid_q && axi_arready;
    assign r_hs      = axi_rvalid && out_ready;
    // Beats outside a descriptor are passed through but never touch the burst accounting.
    assign rlast_dec = r_hs && axi_rlast && in_busy && (os_q != '0);
    assign last_beat = axi_rvalid && (rx_remain_q == TOTAL_W'(1)) && in_busy;
    assign ar_step   = TOTAL_W'(arlen_q) + TOTAL_W'(1);
    assign ar_left   = ar_remain_q - ar_step;
    assign os_nxt    = os_q + OW'(ar_hs) - OW'(rlast_dec);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            ar_remain_q <= '0;
            rx_remain_q <= '0;
            os_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
            ar_remain_q <= ar_remain_d;
            rx_remain_q <= rx_remain_d;
            os_q        <= os_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept && desc_beats != '0) state_d = S_ISSUE;
            S_ISSUE: if (ar_hs && ar_left == '0)     state_d = S_DRAIN;
            S_DRAIN: if (r_hs && last_beat)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arvalid_d   = arvalid_q;
        ar_remain_d = ar_remain_q;
        rx_remain_d = rx_remain_q;
        os_d        = os_nxt;
        err_d       = err_q;
        if (r_hs && in_busy) rx_remain_d = rx_remain_q - TOTAL_W'(1);
        if (r_hs && axi_rresp != 2'b00) err_d = 1'b1;
        if (accept && desc_beats != '0) begin
            err_d       = 1'b0;
            araddr_d    = desc_addr;
            arlen_d     = burst_len(desc_beats);
            ar_remain_d = desc_beats;
            rx_remain_d = desc_beats;
            arvalid_d   = (os_nxt < OS_MAX);
        end
        // araddr/arlen always describe the next burst; they only move on a handshake.
        if (state_q == S_ISSUE) begin
            if (ar_hs) begin
                ar_remain_d = ar_left;
                araddr_d    = araddr_q + (ASIZE'(ar_step) << SH);
                arlen_d     = burst_len(ar_left);
                arvalid_d   = (ar_left != '0) && (os_nxt < OS_MAX);
            end else if (!arvalid_q) begin
                arvalid_d = (os_nxt < OS_MAX);
            end
        end
    end

    always_comb begin
        desc_ready  = (state_q == S_IDLE);
        busy        = in_busy;
        err         = err_q;
        axi_arid    = IDSIZE'(ARID);
        axi_araddr  = araddr_q;
        axi_arlen   = arlen_q;
        axi_arsize  = 3'(SH);
        axi_arburst = 2'b01;
        axi_arvalid = arvalid_q;
        axi_rready  = out_ready;
        out_data    = axi_rdata;
        out_valid   = axi_rvalid;
        out_last    = last_beat;
    end

endmodule

// File: tb/tb_axi4_rd_desc_burst_gen.sv
// Bench for axi4_rd_desc_burst_gen: table of descriptors, hand sequences, random descriptors vs a burst-list model.
module tb_axi4_rd_desc_burst_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  desc_addr = '0;
    logic [23:0]  desc_beats = '0;
    logic         desc_valid = 1'b0;
    logic         desc_ready, busy, err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [255:0] rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rv = 1'b0;
    logic         rready;
    logic [255:0] out_data;
    logic         out_valid, out_last;
    logic         out_ready = 1'b0;

    axi4_rd_desc_burst_gen dut (
        .clock(clk), .rst_n(rst_n),
        .desc_addr(desc_addr), .desc_beats(desc_beats), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .busy(busy), .err(err),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
        .axi_arburst(arburst), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast), .axi_rvalid(rv),
        .axi_rready(rready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] a; logic [7:0] l;} ar_t;
    typedef struct {
        logic [31:0] addr; int beats; int bad; int exp_ars; logic [7:0] exp_last_len; logic exp_err;
    } vec_t;

    int  errors = 0, checks = 0;
    ar_t ar_log[$];
    ar_t exp_q[$];
    int  pend[$];
    int  mode = 1;          // 0 random arready, 1 always ready, 2 held low
    bit  r_en = 1, or_rand = 1, slave_clr = 0;
    int  bad_beat = 0, beat_cnt = 0, last_cnt = 0, last_idx = 0, viol = 0;
    int  stall_cnt = 0, os = 0, os_max = 0, rlast_total = 0, r_beat = 0;
    bit  bad_seen = 0, last_prev = 0, bad_prev = 0, stall_prev = 0, rv_hold = 0;
    logic [31:0] st_a;
    logic [7:0]  st_l;
    logic        err_model = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: chop the descriptor into bursts of at most 128 beats, 32 bytes per beat.
    function automatic void build_exp(input logic [31:0] addr, input int beats);
        int rem, n;
        exp_q.delete();
        rem = beats;
        while (rem > 0) begin
            n = (rem > 128) ? 128 : rem;
            exp_q.push_back('{a: addr, l: 8'(n - 1)});
            addr = addr + 32'(n * 32);
            rem -= n;
        end
    endfunction

    // AXI slave, downstream sink and protocol monitor; acts on the falling edge only.
    initial begin
        forever begin
            @(negedge clk);
            if (slave_clr) begin
                pend.delete(); r_beat = 0; os = 0; rv = 1'b0; rv_hold = 0; slave_clr = 0;
            end
            case (mode)
                0:       arready = 1'($urandom_range(0, 1));
                1:       arready = 1'b1;
                default: arready = 1'b0;
            endcase
            if (!rv_hold) begin
                if (r_en && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                    rv    = 1'b1;
                    rdata = {8{$urandom}};
                    rlast = (r_beat == pend[0] - 1);
                    rresp = (beat_cnt + 1 == bad_beat) ? 2'b10 : 2'b00;
                end else begin
                    rv = 1'b0;
                end
            end
            out_ready = or_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (last_prev && !(desc_ready && !busy)) viol++;
            if (bad_prev && !err) viol++;
            if (stall_prev && !(arvalid && araddr == st_a && arlen == st_l)) viol++;
            if (err && busy && !bad_seen) viol++;
            last_prev = 0; bad_prev = 0; stall_prev = 0;
            if (arvalid && arready) begin
                ar_log.push_back('{a: araddr, l: arlen});
                pend.push_back(int'(arlen) + 1);
                os++;
            end else if (arvalid) begin
                stall_prev = 1; st_a = araddr; st_l = arlen; stall_cnt++;
            end
            if (rready !== out_ready || out_valid !== rv || (rv && out_data !== rdata)) viol++;
            if (rv && out_ready) begin
                beat_cnt++;
                if (out_last) begin last_cnt++; last_idx = beat_cnt; last_prev = 1; end
                if (rresp != 2'b00) begin bad_prev = 1; bad_seen = 1; end
                if (rlast) begin void'(pend.pop_front()); r_beat = 0; os--; rlast_total++; end
                else r_beat++;
                rv_hold = 0;
            end else begin
                rv_hold = rv;
            end
            if (os > os_max) os_max = os;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_desc(input logic [31:0] a, input int beats, input int bad);
        bit rdy, acc;
        ar_log.delete();
        beat_cnt = 0; last_cnt = 0; last_idx = 0; viol = 0; bad_seen = 0;
        stall_cnt = 0; os_max = os; bad_beat = bad; acc = 0;
        desc_addr = a; desc_beats = 24'(beats); desc_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rdy = desc_ready;
            cycles(1);
            if (rdy) begin acc = 1; break; end
        end
        desc_valid = 1'b0;
        chk("accept", 64'(acc), 1);
        if (beats > 0) begin
            err_model = (bad >= 1 && bad <= beats);
            chk("busy_after_accept", 64'(busy), 1);
            chk("arvalid_latency", 64'(arvalid), 1);
            chk("err_clear_on_accept", 64'(err), 0);
        end else begin
            chk("zero_beats_idle", 64'(busy), 0);
        end
    endtask

    task automatic finish_desc(input logic [31:0] a, input int beats);
        if (beats > 0) begin
            for (int i = 0; i < 20000; i++) begin
                if (!busy) break;
                cycles(1);
            end
            chk("done_in_time", 64'(busy), 0);
        end
        cycles(3);
        build_exp(a, beats);
        chk("ar_count", 64'(ar_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ar_log.size(); i++)
            chk($sformatf("ar[%0d]", i), 64'(ar_log[i]), 64'(exp_q[i]));
        chk("beat_count", 64'(beat_cnt), 64'(beats));
        chk("out_last_count", 64'(last_cnt), (beats > 0) ? 64'd1 : 64'd0);
        chk("out_last_index", 64'(last_idx), 64'(beats));
        chk("err_state", 64'(err), 64'(err_model));
        chk("protocol_viol", 64'(viol), 0);
        chk("outstanding_le_4", 64'(os_max <= 4), 1);
        chk("ar_consts", {arid, arsize, arburst}, {4'd0, 3'd5, 2'b01});
    endtask

    task automatic run_desc(input logic [31:0] a, input int beats, input int bad);
        start_desc(a, beats, bad);
        finish_desc(a, beats);
    endtask

    vec_t tbl[8];
    int   rl0, nb;
    logic [31:0] ra;

    initial begin
        tbl[0] = '{32'h0000_1000, 300, 0, 3, 8'd43,  1'b0};
        tbl[1] = '{32'h0000_0040, 1,   0, 1, 8'd0,   1'b0};
        tbl[2] = '{32'h0000_0000, 128, 0, 1, 8'd127, 1'b0};
        tbl[3] = '{32'h0000_0080, 129, 0, 2, 8'd0,   1'b0};
        tbl[4] = '{32'hFFFF_F000, 256, 0, 2, 8'd127, 1'b0};
        tbl[5] = '{32'h0000_0020, 16,  7, 1, 8'd15,  1'b1};
        tbl[6] = '{32'h0000_0000, 0,   0, 0, 8'd0,   1'b1};
        tbl[7] = '{32'h0000_0100, 257, 0, 3, 8'd0,   1'b0};

        #2;
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_araddr", 64'(araddr), 0);
        chk("rst_arlen", 64'(arlen), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_busy", 64'(busy), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        chk("rst_desc_ready", 64'(desc_ready), 1);

        foreach (tbl[i]) begin
            run_desc(tbl[i].addr, tbl[i].beats, tbl[i].bad);
            chk($sformatf("tbl%0d_nar", i), 64'(ar_log.size()), 64'(tbl[i].exp_ars));
            if (ar_log.size() > 0)
                chk($sformatf("tbl%0d_lastlen", i), 64'(ar_log[$].l), 64'(tbl[i].exp_last_len));
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
        end

        // Outstanding cap: no R data, 4 ARs, then the 5th only after an rlast.
        r_en = 0;
        start_desc(32'h0, 1024, 0);
        cycles(30);
        chk("cap_ar_count", 64'(ar_log.size()), 4);
        chk("cap_arvalid_low", 64'(arvalid), 0);
        rl0 = rlast_total;
        r_en = 1;
        for (int i = 0; i < 5000; i++) begin
            if (ar_log.size() >= 5) break;
            cycles(1);
        end
        chk("cap_fifth_issued", 64'(ar_log.size() >= 5), 1);
        chk("cap_fifth_after_rlast", 64'(rlast_total - rl0 >= 1), 1);
        finish_desc(32'h0, 1024);

        // arready held low while a burst is pending.
        mode = 2;
        start_desc(32'h1000, 300, 0);
        cycles(7);
        mode = 1;
        finish_desc(32'h1000, 300);
        chk("stall_cycles", 64'(stall_cnt >= 5), 1);

        // Reset in the middle of ISSUE.
        mode = 2;
        start_desc(32'h1000, 1024, 0);
        cycles(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_arvalid", 64'(arvalid), 0);
        chk("midrst_busy", 64'(busy), 0);
        slave_clr = 1;
        err_model = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        chk("midrst_desc_ready", 64'(desc_ready), 1);
        mode = 1;
        run_desc(32'h1000, 300, 0);

        for (int k = 0; k < 12; k++) begin
            mode = $urandom_range(0, 1);
            ra   = $urandom & 32'hFFFF_FFE0;
            nb   = $urandom_range(1, 700);
            run_desc(ra, nb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
